// File: rtl/mtimer_pkg.sv
// Shared constants and types for the multi-channel interval timer.
// Register offsets, CONTROL/STATUS bit positions and the decoded write-strobe bundle.
package mtimer_pkg;

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_CONTROL  = 3'd1;
  localparam logic [2:0] OFF_PERIOD   = 3'd2;
  localparam logic [2:0] OFF_SNAP     = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int STS_TO  = 0;
  localparam int STS_RUN = 1;

  typedef struct packed {
    logic status;
    logic control;
    logic period;
    logic snap;
    logic prescale;
  } mtimer_wr_t;

endpackage

// File: rtl/avalon_multi_timer_if.sv
// Avalon-MM slave bus bundle for avalon_multi_timer.
// ADDR_W must equal $clog2(NUM_CH)+3 of the attached timer.
interface avalon_multi_timer_if #(parameter int ADDR_W = 4);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/mtimer_channel.sv
// One timer channel: down-counter, RUN/TO, CONTROL, PERIOD, SNAP.
// MTIMER_PRESCALE_EN adds an 8-bit PRESCALE register and prescale counter.
module mtimer_channel
  import mtimer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'd49999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  mtimer_wr_t       wr,
  input  logic [31:0]      wdata,
  output logic [1:0]       status,
  output logic [3:0]       control,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap,
  output logic [7:0]       prescale,
  output logic             irq,
  output logic             tick
);
  localparam logic [CNT_W-1:0] RST_P = RESET_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0] cnt, cnt_d;
  logic run, to, reload_q, tick_en, tmo, start_w, stop_w;
  logic unused_bits;

  assign start_w     = wr.control & wdata[CTL_START];
  assign stop_w      = wr.control & wdata[CTL_STOP];
  assign unused_bits = ^{wdata, wr};

`ifdef MTIMER_PRESCALE_EN
  logic [7:0] pcnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (wr.prescale) prescale <= wdata[7:0];
      if (wr.period || start_w) pcnt <= prescale;
      else if (run)             pcnt <= (pcnt == 8'd0) ? prescale : pcnt - 8'd1;
    end
  end
  assign tick_en = (pcnt == 8'd0);
`else
  assign prescale = '0;
  assign tick_en  = 1'b1;
`endif

  // A pending PERIOD reload overrides counting, whether or not RUN is set.
  always_comb begin
    cnt_d = cnt;
    if (reload_q)            cnt_d = period;
    else if (run && tick_en) cnt_d = (cnt != '0) ? cnt - CNT_W'(1) : period;
    tmo = (cnt != '0) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= RST_P;
      period   <= RST_P;
      snap     <= '0;
      control  <= '0;
      run      <= 1'b0;
      to       <= 1'b0;
      reload_q <= 1'b0;
      tick     <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      reload_q <= wr.period;
      tick     <= tmo;
      // The event term wins over a same-cycle clear so no timeout is lost.
      to       <= (to & ~wr.status) | tmo;
      if (wr.period)  period  <= wdata[CNT_W-1:0];
      if (wr.control) control <= wdata[3:0];
      if (wr.snap)    snap    <= cnt;
      if (start_w)                                            run <= 1'b1;
      else if (stop_w || wr.period || (tmo && !control[CTL_CONT])) run <= 1'b0;
    end
  end

  always_comb begin
    status          = '0;
    status[STS_TO]  = to;
    status[STS_RUN] = run;
  end

  assign irq = to & control[CTL_ITO];

endmodule

// File: rtl/avalon_multi_timer.sv
// NUM_CH-channel Avalon-MM interval timer: address decode, channel array, registered read mux.
// Define MTIMER_PRESCALE_EN to enable the per-channel prescaler at offset 4.
module avalon_multi_timer
  import mtimer_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'd49999
) (
  input  logic                 clk,
  input  logic                 reset_n,
  avalon_multi_timer_if.slave  bus,
  output logic                 irq,
  output logic [NUM_CH-1:0]    tick_out
);
  localparam int AW = $clog2(NUM_CH) + 3;

  logic [AW-1:0] addr, ch_idx;
  logic [2:0]    off;
  logic          wr_en;
  logic [31:0]   rd_d;

  mtimer_wr_t [NUM_CH-1:0]            wr;
  logic [NUM_CH-1:0][1:0]             status;
  logic [NUM_CH-1:0][3:0]             control;
  logic [NUM_CH-1:0][CNT_W-1:0]       period;
  logic [NUM_CH-1:0][CNT_W-1:0]       snap;
  logic [NUM_CH-1:0][7:0]             prescale;
  logic [NUM_CH-1:0]                  ch_irq;

  assign addr   = bus.address;
  assign ch_idx = addr >> 3;
  assign off    = addr[2:0];
  assign wr_en  = bus.chipselect & ~bus.write_n;

  // Channel indices >= NUM_CH never match, so such writes land nowhere.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit            = wr_en && (ch_idx == AW'(i));
    assign wr[i].status   = hit && (off == OFF_STATUS);
    assign wr[i].control  = hit && (off == OFF_CONTROL);
    assign wr[i].period   = hit && (off == OFF_PERIOD);
    assign wr[i].snap     = hit && (off == OFF_SNAP);
    assign wr[i].prescale = hit && (off == OFF_PRESCALE);

    mtimer_channel #(.CNT_W(CNT_W), .RESET_PERIOD(RESET_PERIOD)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr       (wr[i]),
      .wdata    (bus.writedata),
      .status   (status[i]),
      .control  (control[i]),
      .period   (period[i]),
      .snap     (snap[i]),
      .prescale (prescale[i]),
      .irq      (ch_irq[i]),
      .tick     (tick_out[i])
    );
  end

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == AW'(i)) begin
        case (off)
          OFF_STATUS:   rd_d = 32'(status[i]);
          OFF_CONTROL:  rd_d = 32'(control[i]);
          OFF_PERIOD:   rd_d = 32'(period[i]);
          OFF_SNAP:     rd_d = 32'(snap[i]);
          OFF_PRESCALE: rd_d = 32'(prescale[i]);
          default:      rd_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_d;
  end

  assign irq = |ch_irq;

endmodule

// File: doc/avalon_multi_timer.md
# avalon_multi_timer

Parametrised multi-channel Avalon-MM interval timer, the successor to the single-channel 16-bit-bus timer in the Nios II systems. It provides NUM_CH independent down-counters of CNT_W bits behind one 32-bit slave port. Each channel has one-shot/continuous mode, snapshot, a per-channel interrupt and a tick strobe. All channel interrupts are combined onto one irq line.

## Interface
- NUM_CH, 2: channel count, 1..8
- CNT_W, 32: counter/period width, 8..32
- RESET_PERIOD, 32'd49999: period value of every channel after reset, truncated to CNT_W
- clk  in  1: system clock
- reset_n  in  1: asynchronous, active-low reset
- address  in  $clog2(NUM_CH)+3 (minimum 3): word address, {channel, offset[2:0]}
- chipselect  in  1: slave select
- write_n  in  1: active-low write strobe
- writedata  in  32: write data; bits above CNT_W are ignored
- readdata  out  32: registered read data, zero-extended
- irq  out  1: OR of all channel irqs
- tick_out  out  NUM_CH: one-cycle pulse per channel on each timeout event

## Operation
- Write strobe: chipselect && !write_n. A channel index ≥ NUM_CH decodes to nothing and reads 0.
- Register offsets within a channel:
  - 0 STATUS: bit0 TO (timeout sticky), bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO (irq enable), bit1 CONT, bit2 START, bit3 STOP (strobes, also stored). Reads return the stored 4 bits.
  - 2 PERIOD: RW, CNT_W bits.
  - 3 SNAP: a write latches the counter; a read returns the latched value.
  - 4 PRESCALE: only with the macro; otherwise reads 0.
  - 5–7: read 0.
- Counter behaviour while RUN is set and a tick enable is asserted:
  - Counter ≠ 0: decrement.
  - Counter = 0: reload PERIOD.
- Timeout interval: P+1 ticks for PERIOD = P.
- Timeout event: counter becomes 0 while it was non-zero on the previous cycle (edge-detected).
- On a timeout event: set TO and pulse tick_out[ch].
- One-shot stop: counter = 0 with CONT = 0 clears RUN.
- PERIOD write:
  - Forces a reload of the counter on the next cycle, independent of RUN.
  - Clears RUN. Software must re-START.
- START and STOP in the same write: START wins.
- Status-clear write and timeout event in the same cycle: TO ends set, so no event is lost.
- irq[ch] = TO && ITO. irq = OR over all channels.
- Reset values:
  - All counters and PERIOD = RESET_PERIOD.
  - RUN, TO, CONTROL, SNAP = 0.
  - readdata = 0, irq = 0, tick_out = 0.
  - PRESCALE = 0.
- Reset mid-count: everything returns to the reset values asynchronously. No timeout is generated when reset is released.

## Timing
- readdata is registered every cycle from the address, giving one cycle of read latency with no wait states.
- Register writes take effect at the clock edge of the write cycle.
- RUN is visible on the next cycle after START.
- TO sets on the edge where the counter has just reached 0. tick_out and irq rise in the same cycle as TO.
- The forced reload from a PERIOD write occurs one cycle after the write edge.
- The SNAP read value reflects the counter as of the write cycle.

## Configuration
- MTIMER_PRESCALE_EN defined:
  - Per-channel 8-bit PRESCALE register at offset 4.
  - A prescale counter reloads PRESCALE on reaching 0, so the channel ticks every PRESCALE+1 clocks.
  - The prescale counter is reset by a PERIOD write or by START.
- Undefined: the tick enable is constantly 1 and offset 4 reads 0. Timing is identical to PRESCALE = 0.

## Structure
- Package mtimer_pkg holds:
  - Offset constants (OFF_STATUS … OFF_PRESCALE).
  - CONTROL bit indices (CTL_ITO, CTL_CONT, CTL_START, CTL_STOP).
  - STATUS bit indices.
- Sub-module mtimer_channel holds one channel: counter, RUN/TO, CONTROL, PERIOD, SNAP, optional prescaler.
  - Inputs: decoded write strobes and writedata.
  - Outputs: read values, irq, tick.
  - The top level generates NUM_CH instances, the address decode and the read mux/register.

## Test plan
- Reset, PERIOD = 4, CONTROL = 0x7 (ITO|CONT|START) on ch0 -> tick_out[0] every 5 cycles, irq high after the first timeout, STATUS reads 0x3.
- One-shot: ch1 PERIOD = 3, CONTROL = 0x5 -> a single timeout, RUN drops, counter holds 0, no further tick_out[1].
- STATUS write in the same cycle as the ch0 timeout event -> TO stays 1. A write on a later cycle clears TO and irq.
- Write PERIOD = 10 mid-count -> RUN = 0, the counter reads 10 via SNAP two cycles later, no irq.
- Two channels with PERIOD 2 and 6 -> irq is the OR of both. Clearing one leaves irq high until the other is cleared. A read of the unused channel index returns 0.
- With MTIMER_PRESCALE_EN, PRESCALE = 3, PERIOD = 1 -> tick every 8 clocks. Without the macro -> every 2 clocks, and offset 4 reads 0.
